// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the mips_pipelined stages.
//   NOP_WORD  - encoding of sll $0,$0,0, the word placed in a flushed slot
//   RESET_PC  - default fetch address after reset
//   OP_*      - primary opcode field values used by decode and benches
//   ifid_t    - contents of the IF/ID pipeline register
package mips_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } ifid_t;

    // Redirect targets are silently word-aligned; misaligned low bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// if_stage_if: groups every non-clock/reset signal of the fetch stage.
//   control in : stall, jmp_taken/jmp_target, br_taken/br_target
//   imem       : imem_addr (out), imem_rdata (in, combinational read)
//   IF/ID out  : ifid_instr, ifid_pc4, ifid_valid
//   status     : pc, fetch_count
// master = the fetch stage itself, slave = its surroundings.
interface if_stage_if;
    logic        stall;
    logic        jmp_taken;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    modport master (
        input  stall, jmp_taken, jmp_target, br_taken, br_target, imem_rdata,
        output imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );

    modport slave (
        output stall, jmp_taken, jmp_target, br_taken, br_target, imem_rdata,
        input  imem_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fetch_count
    );
endinterface

// File: rtl/pipe_reg_ifid.sv
// pipe_reg_ifid: generic pipeline register with hold and clear.
//   clk, rst : clock, synchronous active-high reset (loads CLR_VAL)
//   hold     : keep current contents
//   clear    : load CLR_VAL (bubble); wins over hold
//   d, q     : W-bit payload in/out
// Written width-generic so the later ID/EX, EX/MEM and MEM/WB registers
// can reuse it with their own payload struct.
module pipe_reg_ifid #(
    parameter int           W       = 65,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         hold,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= CLR_VAL;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of mips_pipelined.
//   clk, rst : clock, synchronous active-high reset
//   bus      : if_stage_if.master (redirects, stall, imem port, IF/ID outputs)
// Holds the PC and next-PC mux, drives the instruction memory address, and
// owns the IF/ID register. Edge priority: rst > branch > jump > stall > fetch.
module if_stage #(
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic       clk,
    input  logic       rst,
    if_stage_if.master bus
);
    import mips_pkg::*;

    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic [31:0] count_q;
    logic        redirect;
    logic        advance;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign redirect = bus.br_taken | bus.jmp_taken;
    assign advance  = !redirect && !bus.stall;

    // Branch is older than the jump sitting in ID, so it takes precedence.
    always_comb begin
        pc_next = pc_plus4;
        if (bus.br_taken) begin
            pc_next = word_align(bus.br_target);
        end else if (bus.jmp_taken) begin
            pc_next = word_align(bus.jmp_target);
        end else if (bus.stall) begin
            pc_next = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (advance) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign ifid_d = '{instr: bus.imem_rdata, pc4: pc_plus4, valid: 1'b1};

    // Any redirect kills the word fetched this cycle (branch shadow or the
    // jump's delay slot), so clear takes priority over stall.
    pipe_reg_ifid #(
        .W       ($bits(ifid_t)),
        .CLR_VAL ({NOP_WORD, 32'h0000_0000, 1'b0})
    ) u_ifid (
        .clk   (clk),
        .rst   (rst),
        .hold  (bus.stall),
        .clear (redirect),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.ifid_instr  = ifid_q.instr;
    assign bus.ifid_pc4    = ifid_q.pc4;
    assign bus.ifid_valid  = ifid_q.valid;
    assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_stage_if bus();

    if_stage u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit model_live = 1'b0;

    logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
    logic        m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1111_1111;
            32'h0000_0004: return 32'h2222_2222;
            32'h0000_0008: return 32'h3333_3333;
            default:       return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    always_comb bus.imem_rdata = mem_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the reference model by the same edge.
    task automatic step(input bit r, input bit st, input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt);
        rst            = r;
        bus.stall      = st;
        bus.jmp_taken  = j;
        bus.jmp_target = jt;
        bus.br_taken   = b;
        bus.br_target  = bt;
        @(posedge clk);
        if (r) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
            model_live = 1'b1;
        end else if (b || j) begin
            m_pc    = b ? (bt & 32'hFFFF_FFFC) : (jt & 32'hFFFF_FFFC);
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        end else if (!st) begin
            m_instr = mem_word(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic run(input bit st);
        step(1'b0, st, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (model_live) begin
            check("pc",          bus.pc,          m_pc);
            check("imem_addr",   bus.imem_addr,   m_pc);
            check("ifid_instr",  bus.ifid_instr,  m_instr);
            check("ifid_pc4",    bus.ifid_pc4,    m_pc4);
            check("ifid_valid",  {31'h0, bus.ifid_valid}, {31'h0, m_valid});
            check("fetch_count", bus.fetch_count, m_cnt);
        end
    end

    initial begin
        bus.stall = 1'b0; bus.jmp_taken = 1'b0; bus.jmp_target = '0;
        bus.br_taken = 1'b0; bus.br_target = '0;
        @(negedge clk);

        step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40);
        check("rst_pc",    bus.pc, 32'h0);
        check("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
        check("rst_instr", bus.ifid_instr, 32'h0);
        check("rst_cnt",   bus.fetch_count, 32'h0);

        run(1'b0);
        check("run1_pc",    bus.pc, 32'h4);
        check("run1_instr", bus.ifid_instr, 32'h1111_1111);
        check("run1_pc4",   bus.ifid_pc4, 32'h4);
        check("run1_valid", {31'h0, bus.ifid_valid}, 32'h1);
        run(1'b0);
        check("run2_pc",    bus.pc, 32'h8);
        check("run2_instr", bus.ifid_instr, 32'h2222_2222);
        check("run2_pc4",   bus.ifid_pc4, 32'h8);

        for (int i = 0; i < 2; i++) begin
            run(1'b1);
            check("stall_pc",    bus.pc, 32'h8);
            check("stall_instr", bus.ifid_instr, 32'h2222_2222);
            check("stall_cnt",   bus.fetch_count, 32'h2);
        end
        run(1'b0);
        check("resume_pc",    bus.pc, 32'hC);
        check("resume_instr", bus.ifid_instr, 32'h3333_3333);
        check("resume_cnt",   bus.fetch_count, 32'h3);

        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("jmp_pc",    bus.pc, 32'h40);
        check("jmp_valid", {31'h0, bus.ifid_valid}, 32'h0);
        check("jmp_instr", bus.ifid_instr, 32'h0);
        run(1'b0);
        check("jmp_next_instr", bus.ifid_instr, mem_word(32'h40));
        check("jmp_next_cnt",   bus.fetch_count, 32'h4);

        step(1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h20);
        check("combo_pc",    bus.pc, 32'h20);
        check("combo_valid", {31'h0, bus.ifid_valid}, 32'h0);
        check("combo_cnt",   bus.fetch_count, 32'h4);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h23);
        check("align_pc", bus.pc, 32'h20);

        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pre_pc", bus.pc, 32'hFFFF_FFFC);
        run(1'b0);
        check("wrap_pc",    bus.pc, 32'h0);
        check("wrap_pc4",   bus.ifid_pc4, 32'h0);
        check("wrap_valid", {31'h0, bus.ifid_valid}, 32'h1);
        check("wrap_cnt",   bus.fetch_count, 32'h5);

        for (int i = 0; i < 5; i++) run(1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0);
        check("pre_rst_pc",  bus.pc, 32'h40);
        check("pre_rst_cnt", bus.fetch_count, 32'd10);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("midrst_pc",    bus.pc, 32'h0);
        check("midrst_valid", {31'h0, bus.ifid_valid}, 32'h0);
        check("midrst_cnt",   bus.fetch_count, 32'h0);
        run(1'b0);
        check("post_rst_pc",    bus.pc, 32'h4);
        check("post_rst_instr", bus.ifid_instr, 32'h1111_1111);
        check("post_rst_cnt",   bus.fetch_count, 32'h1);

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt;
            bt = $urandom;
            if ($urandom_range(0, 3) == 0) bt = 32'hFFFF_FFE0 | {27'h0, bt[4:0]};
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0, $urandom,
                 $urandom_range(0, 9) == 0, bt);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
